// File: rtl/tea_word_rx.sv
// tea_word_rx: collects the two MSB-first serial result lanes of the TEA core
// into WORD_W-bit word pairs and queues them in a FIFO with a valid/ready drain.
//
// Ports:
//   clk        - single clock, all logic on the rising edge
//   reset      - synchronous active-high clear of all state
//   start      - current bit is the MSB of a new pair (needs in_valid)
//   in_valid   - v0_in/v1_in carry a valid bit this cycle
//   v0_in      - serial v0 lane, MSB first
//   v1_in      - serial v1 lane, MSB first
//   out_ready  - consumer accepts the head when out_valid is high
//   out_valid  - FIFO head holds a word pair
//   v0_word    - FIFO head, v0 word
//   v1_word    - FIFO head, v1 word
//   busy       - a word pair is being assembled
//   overflow   - sticky, a completed pair was dropped on a full FIFO
//   frame_err  - sticky, start arrived mid-word and the partial was dropped
module tea_word_rx #(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic              v0_in,
  input  logic              v1_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] v0_word,
  output logic [WORD_W-1:0] v1_word,
  output logic              busy,
  output logic              overflow,
  output logic              frame_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WORD_W + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Only WORD_W-1 bits are ever held: the last bit goes
  // straight from the lane into the FIFO.
  logic [WORD_W-2:0] sr0_q, sr0_d;
  logic [WORD_W-2:0] sr1_q, sr1_d;

  logic [WORD_W-1:0] asm0, asm1;
  logic              push;
  logic              ferr_set;

  logic [WORD_W-1:0] mem0_q [FIFO_DEPTH];
  logic [WORD_W-1:0] mem1_q [FIFO_DEPTH];
  logic [PW:0]       wr_q, rd_q;
  logic              ovf_q, ferr_q;

  logic empty, full, pop, do_push, ovf_set;

  assign asm0 = {sr0_q, v0_in};
  assign asm1 = {sr1_q, v1_in};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr0_d    = sr0_q;
    sr1_d    = sr1_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && start) begin
          state_d = SHIFT;
          sr0_d   = {{(WORD_W-2){1'b0}}, v0_in};
          sr1_d   = {{(WORD_W-2){1'b0}}, v1_in};
          cnt_d   = CW'(1);
        end
      end
      SHIFT: begin
        if (in_valid) begin
          if (start) begin
            // Resync on the new MSB; partial word is lost.
            ferr_set = 1'b1;
            sr0_d    = {{(WORD_W-2){1'b0}}, v0_in};
            sr1_d    = {{(WORD_W-2){1'b0}}, v1_in};
            cnt_d    = CW'(1);
          end else if (cnt_q == CW'(WORD_W - 1)) begin
            push    = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            sr0_d = asm0[WORD_W-2:0];
            sr1_d = asm1[WORD_W-2:0];
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr0_q   <= '0;
      sr1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr0_q   <= sr0_d;
      sr1_q   <= sr1_d;
    end
  end

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) &&
                 (wr_q[PW-1:0] == rd_q[PW-1:0]);

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes the push when the head leaves
  // in the same cycle.
  assign do_push   = push && (!full || pop);
  assign ovf_set   = push && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem0_q[i] <= '0;
        mem1_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem0_q[wr_q[PW-1:0]] <= asm0;
        mem1_q[wr_q[PW-1:0]] <= asm1;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (ovf_set) ovf_q <= 1'b1;
      if (ferr_set) ferr_q <= 1'b1;
    end
  end

  assign v0_word   = mem0_q[rd_q[PW-1:0]];
  assign v1_word   = mem1_q[rd_q[PW-1:0]];
  assign busy      = (state_q == SHIFT);
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_tea_word_rx.sv
// tb_tea_word_rx: directed checks of the serial word-pair receiver.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_tea_word_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        v0_in = 1'b0;
  logic        v1_in = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] v0_word;
  logic [31:0] v1_word;
  logic        busy;
  logic        overflow;
  logic        frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  tea_word_rx #(.WORD_W(32), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .v0_in     (v0_in),
    .v1_in     (v1_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .v0_word   (v0_word),
    .v1_word   (v1_word),
    .busy      (busy),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic send_bit(input logic s, input logic a, input logic b,
                          input logic rdy);
    in_valid  = 1'b1;
    start     = s;
    v0_in     = a;
    v1_in     = b;
    out_ready = rdy;
    tick();
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
  endtask

  // Sends bits 31..lo of a pair; start on bit 31. Checks busy on
  // every cycle of assembly, and out_valid low when want_empty.
  task automatic send_bits(input logic [31:0] w0, input logic [31:0] w1,
                           input int lo, input bit gaps,
                           input bit want_empty);
    for (int i = 31; i >= lo; i--) begin
      if (gaps && i != 31) begin
        int g = $urandom_range(0, 5);
        for (int k = 0; k < g; k++) begin
          tick();
          chk("gap_busy", {31'b0, busy}, 32'd1);
        end
      end
      if (want_empty) chk("early_valid", {31'b0, out_valid}, 32'd0);
      send_bit(i == 31, w0[i], w1[i], 1'b0);
      if (i != 0) chk("busy", {31'b0, busy}, 32'd1);
    end
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] e0,
                          input logic [31:0] e1);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_v0"}, v0_word, e0);
    chk({tag, "_v1"}, v1_word, e1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ov"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_v0"}, v0_word, 32'd0);
    chk({tag, "_v1"}, v1_word, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_ovf"}, {31'b0, overflow}, 32'd0);
    chk({tag, "_ferr"}, {31'b0, frame_err}, 32'd0);
  endtask

  initial begin
    // T1 basic
    reset = 1'b1;
    tick();
    tick();
    chk_zero("t1_rst");
    reset = 1'b0;
    tick();
    send_bits(32'h01234567, 32'h89ABCDEF, 0, 1'b0, 1'b1);
    chk_head("t1", 32'h01234567, 32'h89ABCDEF);
    chk("t1_busy", {31'b0, busy}, 32'd0);
    pop_one();
    chk("t1_pop", {31'b0, out_valid}, 32'd0);

    // T2 gaps
    send_bits(32'h01234567, 32'h89ABCDEF, 0, 1'b1, 1'b1);
    chk_head("t2", 32'h01234567, 32'h89ABCDEF);
    pop_one();
    chk("t2_pop", {31'b0, out_valid}, 32'd0);

    // T3 backpressure / overflow
    do_reset();
    send_bits(32'd1, 32'd2, 0, 1'b0, 1'b1);
    send_bits(32'd3, 32'd4, 0, 1'b0, 1'b0);
    chk("t3_ovf2", {31'b0, overflow}, 32'd0);
    send_bits(32'd5, 32'd6, 0, 1'b0, 1'b0);
    chk("t3_ovf3", {31'b0, overflow}, 32'd1);
    tick();
    chk_head("t3_h1", 32'd1, 32'd2);
    pop_one();
    chk_head("t3_h2", 32'd3, 32'd4);
    pop_one();
    chk("t3_empty", {31'b0, out_valid}, 32'd0);
    chk("t3_ovf_sticky", {31'b0, overflow}, 32'd1);

    // T4 push and pop on a full FIFO in the same cycle
    do_reset();
    send_bits(32'hA, 32'hB, 0, 1'b0, 1'b1);
    send_bits(32'hC, 32'hD, 0, 1'b0, 1'b0);
    send_bits(32'd7, 32'd8, 1, 1'b0, 1'b0);
    chk_head("t4_h0", 32'hA, 32'hB);
    send_bit(1'b0, 1'b1, 1'b0, 1'b1);
    chk("t4_ovf", {31'b0, overflow}, 32'd0);
    chk_head("t4_h1", 32'hC, 32'hD);
    pop_one();
    chk_head("t4_h2", 32'd7, 32'd8);
    pop_one();
    chk("t4_empty", {31'b0, out_valid}, 32'd0);

    // T5 framing error
    do_reset();
    send_bits(32'hFFC00000, 32'h55400000, 22, 1'b0, 1'b1);
    chk("t5_ferr0", {31'b0, frame_err}, 32'd0);
    send_bits(32'hDEADBEEF, 32'hCAFEF00D, 0, 1'b0, 1'b1);
    chk("t5_ferr1", {31'b0, frame_err}, 32'd1);
    chk_head("t5", 32'hDEADBEEF, 32'hCAFEF00D);
    pop_one();
    chk("t5_only", {31'b0, out_valid}, 32'd0);

    // T6 reset mid-word
    do_reset();
    send_bits(32'h11, 32'h22, 0, 1'b0, 1'b1);
    send_bits(32'h12345678, 32'h9ABCDEF0, 16, 1'b0, 1'b0);
    chk("t6_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    in_valid = 1'b1;
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    chk_zero("t6_rst");
    // start without in_valid, and in_valid without start, do nothing
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_nostart", {31'b0, busy}, 32'd0);
    send_bit(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t6_noval", {31'b0, busy}, 32'd0);
    send_bits(32'h600DF00D, 32'h0BADCAFE, 0, 1'b0, 1'b1);
    chk_head("t6", 32'h600DF00D, 32'h0BADCAFE);
    pop_one();
    chk("t6_empty", {31'b0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
